// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Multi-channel IJTAG/functional data mux with a registered break-before-make hand-over per channel.
// Optional capture register bank enabled by defining TESSENT_DATA_MUX_CAPTURE_EN.
module firebird7_in_gate1_tessent_data_mux_seq #(
   parameter int unsigned WIDTH    = 19,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SETTLE   = 2
) (
   input  logic                      ijtag_tck,
   input  logic                      ijtag_reset,
   input  logic [CHANNELS-1:0]       ijtag_select,
   input  logic [CHANNELS*WIDTH-1:0] functional_data_in,
   input  logic [CHANNELS*WIDTH-1:0] ijtag_data_in,
   output logic [CHANNELS*WIDTH-1:0] data_out,
   output logic [CHANNELS-1:0]       ijtag_active
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
   ,
   output logic [CHANNELS*WIDTH-1:0] capture_data_out
`endif
);

   typedef enum logic [1:0] {
      S_FUNC     = 2'd0,
      S_HOLD_IN  = 2'd1,
      S_IJTAG    = 2'd2,
      S_HOLD_OUT = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_hold;
      logic [WIDTH-1:0] w_hold_nxt;
      logic [3:0]       r_cnt;
      logic [3:0]       w_cnt_nxt;
      logic [WIDTH-1:0] w_func;
      logic [WIDTH-1:0] w_ijtag;
      logic [WIDTH-1:0] w_out;

      assign w_func  = functional_data_in[ch*WIDTH +: WIDTH];
      assign w_ijtag = ijtag_data_in[ch*WIDTH +: WIDTH];

      // Abort (select reverting) takes priority over counter expiry in both hold states.
      always_comb begin
         w_state_nxt = r_state;
         w_hold_nxt  = r_hold;
         w_cnt_nxt   = r_cnt;
         unique case (r_state)
            S_FUNC: begin
               if (ijtag_select[ch]) begin
                  w_state_nxt = S_HOLD_IN;
                  w_hold_nxt  = w_func;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
            S_HOLD_IN: begin
               if (!ijtag_select[ch])    w_state_nxt = S_FUNC;
               else if (r_cnt == 4'd0)   w_state_nxt = S_IJTAG;
               else                      w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_IJTAG: begin
               if (!ijtag_select[ch]) begin
                  w_state_nxt = S_HOLD_OUT;
                  w_hold_nxt  = w_ijtag;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
            S_HOLD_OUT: begin
               if (ijtag_select[ch])     w_state_nxt = S_IJTAG;
               else if (r_cnt == 4'd0)   w_state_nxt = S_FUNC;
               else                      w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = S_FUNC;
         endcase
      end

      always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
         if (!ijtag_reset) begin
            r_state <= S_FUNC;
            r_hold  <= '0;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      always_comb begin
         w_out = w_func;
         unique case (r_state)
            S_FUNC:     w_out = w_func;
            S_IJTAG:    w_out = w_ijtag;
            S_HOLD_IN,
            S_HOLD_OUT: w_out = r_hold;
            default:    w_out = w_func;
         endcase
      end

      assign data_out[ch*WIDTH +: WIDTH] = w_out;
      assign ijtag_active[ch]            = (r_state == S_IJTAG);

`ifdef TESSENT_DATA_MUX_CAPTURE_EN
      logic [WIDTH-1:0] r_cap;

      always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
         if (!ijtag_reset)                          r_cap <= '0;
         else if (r_state == S_FUNC && ijtag_select[ch]) r_cap <= w_func;
      end

      assign capture_data_out[ch*WIDTH +: WIDTH] = r_cap;
`endif
   end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_seq.sv
// Self-checking bench: directed hand-over scenarios then randomized traffic against a behavioural model.
module tb_firebird7_in_gate1_tessent_data_mux_seq;

   localparam int W  = 19;
   localparam int CH = 2;
   localparam int S  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CH-1:0]   sel;
   logic [CH*W-1:0] func_in;
   logic [CH*W-1:0] ijt_in;
   logic [CH*W-1:0] dout;
   logic [CH-1:0]   active;
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
   logic [CH*W-1:0] cap_out;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Model: each channel rests on a side (0 functional, 1 IJTAG) or is frozen for a number of edges
   // while heading to a target side; reverting the request cancels the freeze.
   int           m_side [CH];
   int           m_tgt  [CH];
   int           m_frz  [CH];
   logic [W-1:0] m_hold [CH];
   logic [W-1:0] m_cap  [CH];

   always #5 clk = ~clk;

   firebird7_in_gate1_tessent_data_mux_seq #(
      .WIDTH    (W),
      .CHANNELS (CH),
      .SETTLE   (S)
   ) dut (
      .ijtag_tck          (clk),
      .ijtag_reset        (rst_n),
      .ijtag_select       (sel),
      .functional_data_in (func_in),
      .ijtag_data_in      (ijt_in),
      .data_out           (dout),
      .ijtag_active       (active)
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
      ,
      .capture_data_out   (cap_out)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_side[c] = 0;
         m_tgt[c]  = 0;
         m_frz[c]  = 0;
         m_hold[c] = '0;
         m_cap[c]  = '0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < CH; c++) begin
         int s;
         s = int'(sel[c]);
         if (m_frz[c] == 0) begin
            if (s != m_side[c]) begin
               m_hold[c] = (m_side[c] == 1) ? ijt_in[c*W +: W] : func_in[c*W +: W];
               if (m_side[c] == 0) m_cap[c] = func_in[c*W +: W];
               m_tgt[c] = s;
               m_frz[c] = S;
            end
         end else if (s != m_tgt[c]) begin
            m_frz[c] = 0;
         end else begin
            m_frz[c]--;
            if (m_frz[c] == 0) m_side[c] = m_tgt[c];
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int c = 0; c < CH; c++) begin
         logic [W-1:0] e;
         if (m_frz[c] > 0)       e = m_hold[c];
         else if (m_side[c] == 1) e = ijt_in[c*W +: W];
         else                    e = func_in[c*W +: W];
         chk($sformatf("%s_data%0d", tag, c), 64'(dout[c*W +: W]), 64'(e));
         chk($sformatf("%s_act%0d", tag, c), 64'(active[c]),
             64'((m_frz[c] == 0 && m_side[c] == 1) ? 1 : 0));
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
         chk($sformatf("%s_cap%0d", tag, c), 64'(cap_out[c*W +: W]), 64'(m_cap[c]));
`endif
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      sel     = '0;
      func_in = '0;
      ijt_in  = '0;
      func_in[0 +: W] = 19'h12345;
      ijt_in [0 +: W] = 19'h7FFFF;
      func_in[W +: W] = 19'h0BEEF;
      ijt_in [W +: W] = 19'h31337;
      model_reset();
      #1;
      check_all("rst");
      chk("rst_lit", 64'(dout[0 +: W]), 64'h12345);
      step("rst_edge");
      rst_n = 1'b1;
      #1;
      check_all("rst_rel");

      // switch in on channel 0
      sel[0] = 1'b1;
      step("swin1");
      chk("swin1_lit", 64'(dout[0 +: W]), 64'h12345);
      func_in[0 +: W] = 19'h00001;
      #1;
      check_all("swin1_fchg");
      step("swin2");
      chk("swin2_lit", 64'(dout[0 +: W]), 64'h12345);
      step("swin3");
      chk("swin3_lit", 64'(dout[0 +: W]), 64'h7FFFF);
      chk("swin3_act", 64'(active[0]), 64'd1);
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
      chk("swin_cap_lit", 64'(cap_out[0 +: W]), 64'h12345);
`endif

      // switch out
      ijt_in[0 +: W] = 19'h55555;
      #1;
      check_all("ijt_pass");
      sel[0] = 1'b0;
      step("swout1");
      chk("swout1_lit", 64'(dout[0 +: W]), 64'h55555);
      chk("swout1_act", 64'(active[0]), 64'd0);
      ijt_in[0 +: W] = 19'h0AAAA;
      #1;
      check_all("swout1_ichg");
      step("swout2");
      chk("swout2_lit", 64'(dout[0 +: W]), 64'h55555);
      step("swout3");
      chk("swout3_lit", 64'(dout[0 +: W]), 64'h00001);

      // abort in HOLD_IN
      sel[0] = 1'b1;
      step("abin1");
      sel[0] = 1'b0;
      step("abin2");
      chk("abin2_act", 64'(active[0]), 64'd0);
      step("abin3");
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
      chk("abin_cap_lit", 64'(cap_out[0 +: W]), 64'h00001);
`endif

      // abort in HOLD_OUT
      sel[0] = 1'b1;
      repeat (S + 1) step("about_in");
      sel[0] = 1'b0;
      step("about1");
      sel[0] = 1'b1;
      step("about2");
      chk("about2_act", 64'(active[0]), 64'd1);
      chk("about2_lit", 64'(dout[0 +: W]), 64'h0AAAA);

      // channel 1 toggles while channel 0 stays in IJTAG
      for (int k = 0; k < 6; k++) begin
         sel[1] = ~sel[1];
         step("indep");
         chk("indep_act0", 64'(active[0]), 64'd1);
      end
      sel[1] = 1'b0;
      repeat (S + 2) step("indep_settle");

      // asynchronous reset in the middle of a hand-over
      sel[1] = 1'b1;
      step("mid_hin");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("mid_rst");
      chk("mid_rst_lit", 64'(dout[W +: W]), 64'(func_in[W +: W]));
      sel = '0;
      #1;
      rst_n = 1'b1;
      step("mid_rel");

      // randomized traffic with occasional mid-cycle resets
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(3) == 0) sel[c] = ~sel[c];
         for (int c = 0; c < CH; c++) begin
            func_in[c*W +: W] = W'($urandom);
            ijt_in [c*W +: W] = W'($urandom);
         end
         #1;
         check_all("rnd_comb");
         if ($urandom_range(40) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("rnd_rst");
            rst_n = 1'b1;
         end
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
